// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction issue for the 8-bit accumulator core.
// Reads the instruction ROM at the PC, issues the word downstream, and takes the
// ALU branch decision back in the same cycle to select the next PC.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | out of reset, waiting for start_i; PC parked at START_PC
// S_RUN   | issuing one instruction per cycle
// S_HALTED| HALT seen; done_o high, PC parked on the HALT word
module fetch_unit #(
    parameter int          PC_W     = 10,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter logic [4:0]  HALT_OP  = 5'h1F,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start_i,
    output logic [PC_W-1:0]  instr_addr_o,
    input  logic [8:0]       instr_i,
    output logic [8:0]       op_o,
    output logic             valid_o,
    input  logic             jump_bit_i,
    input  logic [7:0]       target_i,
    output logic             done_o,
    output logic [CNT_W-1:0] icount_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] icount_q, icount_d;

    logic             is_halt;
    logic [PC_W-1:0]  offset_ext;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_branch;
    logic [CNT_W-1:0] icount_inc;

    // Branch offset is relative to the branch's own address; the signed cast
    // sign-extends for wide PCs and simply truncates when PC_W is below 8.
    assign is_halt    = (instr_i[8:4] == HALT_OP);
    assign offset_ext = PC_W'($signed(target_i));
    assign pc_seq     = pc_q + PC_W'(1);
    assign pc_branch  = pc_q + offset_ext;
    assign icount_inc = (icount_q == {CNT_W{1'b1}}) ? icount_q : icount_q + CNT_W'(1);

    // State, PC and instruction counter registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= START_PC;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
        end
    end

    // Next-state, next-PC and issue logic; HALT outranks any branch request.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        op_o     = 9'h000;
        valid_o  = 1'b0;
        done_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    pc_d     = START_PC;
                    icount_d = '0;
                end
            end
            S_RUN: begin
                if (is_halt) begin
                    state_d = S_HALTED;
                end else begin
                    op_o     = instr_i;
                    valid_o  = 1'b1;
                    icount_d = icount_inc;
                    pc_d     = jump_bit_i ? pc_branch : pc_seq;
                end
            end
            S_HALTED: begin
                done_o = 1'b1;
                if (start_i) begin
                    state_d  = S_RUN;
                    pc_d     = START_PC;
                    icount_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr_addr_o = pc_q;
    assign icount_o     = icount_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter sequencer for the 8-bit accumulator core. It owns the PC, reads the instruction ROM, and issues the 9-bit instruction word that the decoder and ALU consume. It then closes the loop by taking the ALU's `jump_bit` and `result_o` back as a branch request and offset. It also handles start, halt and done sequencing for the testbench, and counts issued instructions.

## Interface
Parameters:
- `PC_W`, default 10: PC and ROM address width. The ROM holds 2^PC_W words.
- `START_PC`, default 0: PC value loaded on every start.
- `HALT_OP`, default 5'h1F: value of instr[8:4] that means HALT.
- `CNT_W`, default 16: width of the instruction counter.

Ports (clock and reset first; one clock, synchronous active-high reset):
- `CLK`, in, 1: the single clock. All state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: begin or restart execution. Sampled in IDLE and HALTED only.
- `instr_addr_o`, out, PC_W: ROM address. Equals the PC register.
- `instr_i`, in, 9: ROM data for `instr_addr_o`. Asynchronous read, valid in the same cycle.
- `op_o`, out, 9: instruction issued to the decoder and ALU.
- `valid_o`, out, 1: `op_o` is a real instruction. When low, downstream treats the cycle as a bubble.
- `jump_bit_i`, in, 1: branch taken, from ALU `jump_bit`.
- `target_i`, in, 8: signed branch offset, from ALU `result_o`.
- `done_o`, out, 1: the core has halted.
- `icount_o`, out, CNT_W: number of instructions issued since the last start.

## Operation
- States: IDLE, RUN, HALTED.
- Reset drives the next edge to: state=IDLE, PC=START_PC, icount=0. Outputs after reset: `done_o`=0, `valid_o`=0, `op_o`=9'h000, `instr_addr_o`=START_PC.
- IDLE: PC holds. `start_i`=1 goes to RUN with PC=START_PC and icount=0.
- RUN, non-HALT instruction (instr_i[8:4] != HALT_OP):
  - `op_o`=`instr_i`, `valid_o`=1.
  - icount increments, saturating at all-ones.
  - If `jump_bit_i`=1: next PC = PC + sign_extend(`target_i`, PC_W), modulo 2^PC_W.
  - Otherwise: next PC = PC+1, modulo 2^PC_W. PC = 2^PC_W−1 wraps to 0.
- RUN, HALT instruction:
  - `op_o`=9'h000, `valid_o`=0.
  - `jump_bit_i` is ignored, PC holds, icount does not increment.
  - Next state is HALTED.
- HALTED: `done_o`=1 and PC holds. `start_i`=1 goes to RUN with PC=START_PC, icount=0 and `done_o` dropping on that edge. `start_i` is ignored in RUN.
- Outside RUN: `op_o`=9'h000, `valid_o`=0, and `jump_bit_i`/`target_i` are ignored.
- Offset arithmetic:
  - `target_i` is two's complement, range −128..+127.
  - It is sign-extended (when PC_W≥8) and added to the current PC, the address of the branch itself.
  - A branch with offset 0 is a self-loop.
  - Underflow below 0 wraps modulo 2^PC_W.
- Priority at any edge: `reset` > HALT detection > `jump_bit_i` > sequential increment.

## Timing
- Single-cycle issue. `instr_addr_o` is registered. `op_o` and `valid_o` are combinational from `instr_i` and the state.
- The ALU resolves `jump_bit_i` in the same cycle, and the new PC appears after the next rising edge. There is no delay slot and no bubble on a taken branch.
- Start to first instruction: `start_i` sampled at edge N gives `valid_o`=1 with PC=START_PC during cycle N+1.
- HALT at PC=h during cycle N: `done_o`=1 from edge N+1 onward, and `instr_addr_o` stays h.
- `reset` asserted mid-RUN: IDLE after the next edge, with `valid_o`=0 in that following cycle. Reset has priority over a coincident `start_i`.
- `icount_o` is registered and reflects instructions issued before the current cycle.

## Test plan
- Reset then idle: hold `reset` for 2 cycles and leave `start_i`=0 for 5 cycles. Expect `instr_addr_o`=0, `valid_o`=0, `done_o`=0, `icount_o`=0 throughout.
- Straight line: ROM[0..3] = non-HALT words, ROM[4] = {5'h1F, 4'h0}, pulse `start_i`. Expect addresses 0,1,2,3,4 on consecutive cycles, then `done_o`=1 holding address 4 and `icount_o`=4.
- Branches: at PC=10 drive `jump_bit_i`=1 with `target_i`=8'hFB, so the next PC is 5. At PC=5 drive `target_i`=8'h7F, so the next PC is 132. With PC_W=10, at PC=3 drive `target_i`=8'hF0, so the next PC is 1011 (wrap).
- Wrap and HALT priority: run sequentially from PC=1023 and expect the next PC to be 0. Put HALT at 0 with `jump_bit_i`=1 and expect no jump, HALTED, and PC=0.
- Restart and mid-run reset: from HALTED, pulse `start_i` and expect PC=START_PC, `icount_o`=0, `done_o`=0 after one edge. Assert `reset` while in RUN at PC=7 and expect IDLE, `valid_o`=0, `instr_addr_o`=0 after one edge. A `start_i` coincident with `reset` must leave the block in IDLE.
